// File: rtl/lcd_io_driver.sv
// HD44780-style write sequencer fed by the core's memory-mapped LCD register.
// Optional macro LCD_IO_CMD_CNT_EN adds o_cmd_cnt, a wrapping count of completed writes.
module lcd_io_driver #(
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 25,
    parameter int HOLD_CYC     = 4,
    parameter int WAIT_CYC     = 2500,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_overrun
`ifdef LCD_IO_CMD_CNT_EN
    ,
    output logic [15:0] o_cmd_cnt
`endif
);

    localparam int CW = $clog2(CLR_WAIT_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic       s_on;
    logic       s_tog;
    logic       s_rs;
    logic [7:0] s_data;
    logic       t_prev;

    logic       pend;
    logic       pend_rs;
    logic [7:0] pend_data;

    logic req;
    logic cnt_done;
    logic wait_end;
    logic is_clear;

    // Only ON, toggle, RS and DATA are architected; the rest of the word is reserved.
    logic unused_io_bits;
    assign unused_io_bits = ^{i_io_lcd[30:11], i_io_lcd[8]};

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of block order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s_on   <= 1'b0;
            s_tog  <= 1'b0;
            s_rs   <= 1'b0;
            s_data <= 8'h00;
            t_prev <= 1'b0;
        end else begin
            s_on   <= i_io_lcd[31];
            s_tog  <= i_io_lcd[10];
            s_rs   <= i_io_lcd[9];
            s_data <= i_io_lcd[7:0];
            t_prev <= s_tog;
        end
    end

    assign req      = s_tog ^ t_prev;
    assign cnt_done = (cnt == '0);
    assign wait_end = (state == ST_WAIT) && cnt_done;
    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign is_clear = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data != 8'h00);

    assign o_lcd_on = s_on;
    assign o_lcd_rw = 1'b0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pend       <= 1'b0;
            pend_rs    <= 1'b0;
            pend_data  <= 8'h00;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state      <= ST_SETUP;
                        cnt        <= SETUP_LD;
                        o_lcd_rs   <= s_rs;
                        o_lcd_data <= s_data;
                        o_busy     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        state    <= ST_PULSE;
                        cnt      <= EN_LD;
                        o_lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_done) begin
                        state    <= ST_HOLD;
                        cnt      <= HOLD_LD;
                        o_lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        state <= ST_WAIT;
                        cnt   <= is_clear ? CLR_LD : WAIT_LD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_done) begin
                        if (pend) begin
                            // Older buffered request goes first; a coincident new one refills the slot.
                            state      <= ST_SETUP;
                            cnt        <= SETUP_LD;
                            o_lcd_rs   <= pend_rs;
                            o_lcd_data <= pend_data;
                            pend       <= req;
                            if (req) begin
                                pend_rs   <= s_rs;
                                pend_data <= s_data;
                            end
                        end else if (req) begin
                            state      <= ST_SETUP;
                            cnt        <= SETUP_LD;
                            o_lcd_rs   <= s_rs;
                            o_lcd_data <= s_data;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    o_lcd_en <= 1'b0;
                    o_busy   <= pend;
                end
            endcase

            if (req && (state != ST_IDLE) && !wait_end) begin
                if (!pend) begin
                    pend      <= 1'b1;
                    pend_rs   <= s_rs;
                    pend_data <= s_data;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef LCD_IO_CMD_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_cmd_cnt <= 16'h0000;
        end else if (wait_end) begin
            o_cmd_cnt <= o_cmd_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: doc/lcd_io_driver.md
Name: lcd_io_driver

Overview:
- Consumer end of the LSU's memory-mapped LCD output register. Takes the 32-bit o_io_lcd word driven by the pipelined core and turns software write requests into HD44780-style write cycles with legal setup, enable-pulse, hold and execution-wait timing.
- Software requests a transaction by toggling bit 10 of the register. This removes the need to bit-bang EN from the program.
- Sits at the top level between the core's o_io_lcd and the board LCD pins.

Parameters:
- SETUP_CYC, 4: cycles RS/DATA are stable before EN rises (≥1).
- EN_CYC, 25: EN high width in cycles (≥1).
- HOLD_CYC, 4: cycles RS/DATA are held after EN falls (≥1).
- WAIT_CYC, 2500: execution wait after a normal command or data write (≥1).
- CLR_WAIT_CYC, 82000: execution wait after clear/home commands (≥WAIT_CYC).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_io_lcd  in  32  LCD register from the LSU: [31] ON, [10] request toggle, [9] RS, [7:0] DATA; all other bits ignored.
- o_lcd_on  out  1  LCD power/backlight.
- o_lcd_en  out  1  LCD enable strobe.
- o_lcd_rs  out  1  register select.
- o_lcd_rw  out  1  read/write; tied 0 (write-only).
- o_lcd_data  out  8  LCD data bus.
- o_busy  out  1  a transaction is in flight or pending.
- o_overrun  out  1  one-cycle pulse: a request was dropped.

Interface rule (already decided): reset i_rst_n, synchronous, active-low; clock i_clk.

Behaviour:
- Input register: i_io_lcd[31], [10], [9], [7:0] are captured every cycle into sample register s. Previous toggle register t_prev is updated from s[10] every cycle.
- Reset: s = 0, t_prev = 0, state IDLE, pending = 0, counter = 0. All outputs are 0.
- Request: req = s[10] ^ t_prev, valid for exactly one cycle per toggle edge. The request captures RS = s[9] and DATA = s[7:0] in that same cycle.
- o_lcd_on = s[31]. One-cycle latency; independent of the FSM.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. Each state except IDLE lasts exactly its parameter's number of cycles.
  - IDLE + req: latch RS/DATA onto o_lcd_rs/o_lcd_data and go to SETUP on the next edge.
  - SETUP → PULSE: o_lcd_en = 1 throughout PULSE only.
  - PULSE → HOLD → WAIT.
  - WAIT duration is CLR_WAIT_CYC if the latched RS = 0 and DATA[7:2] = 0 with DATA ≠ 0 (clear 0x01, home 0x02/0x03). Otherwise it is WAIT_CYC.
  - WAIT end: if pending is set, load the pending RS/DATA, clear pending and go directly to SETUP. Otherwise go to IDLE.
- o_lcd_rs and o_lcd_data change only when entering SETUP. They hold their values through IDLE.
- Pending buffer (1 entry): a req arriving while state ≠ IDLE is stored if pending is empty.
  - If pending is full, the req is dropped and o_overrun pulses high for 1 cycle. Pending keeps its older contents.
- Simultaneous req and WAIT-end with pending empty: the req goes straight to SETUP; nothing is stored.
- Simultaneous req and WAIT-end with pending full: the pending entry goes to SETUP and the req is stored into pending. No overrun.
- o_busy = (state ≠ IDLE) | pending.
- Latency: toggle on i_io_lcd visible at edge k → s updated at k → SETUP entered at edge k+1.
- Cycle count per transaction, SETUP entry to IDLE: SETUP_CYC + EN_CYC + HOLD_CYC + wait.
- Counter: a single down-counter sized to $clog2(CLR_WAIT_CYC+1) bits, reloaded on every state entry.
- Synchronous reset mid-transaction: returns to the reset state next edge; EN drops immediately; pending is discarded.

Optional Feature:
- Macro LCD_IO_CMD_CNT_EN.
- Defined: adds port o_cmd_cnt (out, 16). It increments by 1 on each WAIT exit, wraps 0xFFFF → 0x0000, and resets to 0.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan (SETUP_CYC=2, EN_CYC=3, HOLD_CYC=2, WAIT_CYC=5, CLR_WAIT_CYC=20):
- Reset, then i_io_lcd = 0x8000_0000 → o_lcd_on = 1 one cycle later; o_lcd_en and o_busy stay 0.
- Toggle [10] with RS=1, DATA=0x41 → SETUP one edge after capture. o_lcd_en high exactly 3 cycles, starting 2 cycles after rs=1/data=0x41 appear. o_busy high 12 cycles total.
- Toggle with RS=0, DATA=0x01 → WAIT lasts 20 cycles, o_busy 27 cycles. Repeat with DATA=0x38 → WAIT lasts 5 cycles.
- Three toggles 2 cycles apart (0x41, 0x42, 0x43) → 0x41 then 0x42 are written back-to-back with no IDLE cycle between them. 0x43 is dropped and o_overrun pulses exactly once.
- Assert i_rst_n = 0 during PULSE → next edge o_lcd_en = 0, o_busy = 0, o_lcd_data = 0x00. With pending previously set, no write follows release.
- With LCD_IO_CMD_CNT_EN: 3 accepted writes → o_cmd_cnt = 3. Force 65536 completions → o_cmd_cnt wraps to 0.
